pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline control unit for the 5-stage core; produces the 6-bit stall vector consumed by every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB), plus flush and new_pc.
- Arbitrates stall requests from ID, EX and MEM.
- Contains a multi-cycle EX sequencer: a counted stall for iterative ops such as div/madd.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MC_CNT_W, 6, width of multi-cycle op length field and internal down-counter.
- PERF_W, 32, width of stall-cycle performance counter.
- PC_W, 32, width of exception vector / new_pc.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stallreq_from_id  in  1  load-use interlock request.
- stallreq_from_ex  in  1  single-cycle EX stall request.
- stallreq_from_mem  in  1  memory-wait request.
- ex_mc_start  in  1  EX begins multi-cycle op this cycle.
- ex_mc_cycles  in  MC_CNT_W  total cycles the op occupies EX (N).
- excp_valid  in  1  exception/eret taken this cycle.
- excp_vector  in  PC_W  redirect target.
- stall  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = STOP.
- flush  out  1  squash all pipeline registers.
- new_pc  out  PC_W  redirect PC, valid when flush=1.
- ex_mc_busy  out  1  sequencer not IDLE.
- ex_mc_done  out  1  one-cycle pulse; EX result of multi-cycle op valid.
- stall_cycles  out  PERF_W  count of cycles with stall[0]=1.

Behaviour:
- Reset (rst=1 at posedge):
  - state<=IDLE, counter<=0, ex_mc_done<=0, stall_cycles<=0.
  - While rst=1, combinational outputs are forced: stall=6'b000000, flush=0, new_pc=0.
- Stall vector (combinational), priority highest first:
  - excp_valid: stall=000000, flush=1, new_pc=excp_vector.
  - stallreq_from_mem: stall=011111.
  - stallreq_from_ex OR ex_stall: stall=001111.
  - stallreq_from_id: stall=000111.
  - Otherwise stall=000000.
  - flush=0 and new_pc=0 whenever excp_valid=0.
- Stall encoding guarantees stall[k]=1 implies stall[j]=1 for all j<k. Stage k+1 register inserts a bubble when stall[k]=1 and stall[k+1]=0.
- ex_stall = (state==IDLE && ex_mc_start && ex_mc_cycles!=0) || state==BUSY.
- Multi-cycle sequencer FSM:
  - States: IDLE, BUSY, DONE.
  - IDLE + ex_mc_start + N>=2: counter<=N-2, go BUSY.
  - IDLE + ex_mc_start + N==1: go DONE.
  - IDLE + N==0: start is ignored; no stall, no done pulse.
  - BUSY: counter==0 -> DONE; else counter<=counter-1.
  - DONE: ex_mc_done=1 for exactly this cycle, then -> IDLE. DONE does not assert ex_stall.
  - ex_mc_start is ignored in BUSY and DONE.
  - Net effect: a start at cycle T stalls cycles T..T+N-1, and ex_mc_done is high in cycle T+N.
  - ex_mc_done is a registered output: high iff state==DONE.
  - ex_mc_busy = (state!=IDLE).
- Flush during an op: excp_valid=1 in any state -> next state IDLE, counter<=0, no done pulse. Flush takes priority over a simultaneous start.
- A MEM stall during BUSY still shows stall=011111, and the counter keeps decrementing. The op length is fixed in cycles and is not frozen by downstream stalls.
- Perf counter: increments at posedge when stall[0]=1 and rst=0. It saturates at all-ones and does not wrap.

Test Plan:
- Reset then idle, all requests 0 -> stall=000000, flush=0, ex_mc_busy=0, stall_cycles=0.
- stallreq_from_id=1 and stallreq_from_mem=1 in the same cycle -> stall=011111. Drop mem -> stall=000111.
- ex_mc_start with N=5 at cycle T:
  - stall=001111 in cycles T..T+4.
  - ex_mc_done=1 only in T+5.
  - stall_cycles advances by 5.
- N=1 -> stall in cycle T only, done in T+1. N=0 -> no stall, no done.
- Start N=8; at T+3 assert excp_valid with excp_vector=0xBFC00380:
  - That cycle: stall=000000, flush=1, new_pc=0xBFC00380.
  - T+4: ex_mc_busy=0, and ex_mc_done never pulses.
- Preload stall_cycles near max (2^PERF_W-2, via small-PERF_W build with PERF_W=4), then hold stallreq_from_id -> counter reaches 15 and holds.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage core: stall-vector arbitration, exception flush,
// multi-cycle EX sequencer and a saturating stall-cycle counter.
module pipe_ctrl #(
    parameter int MC_CNT_W = 6,
    parameter int PERF_W   = 32,
    parameter int PC_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_from_id,
    input  logic                stallreq_from_ex,
    input  logic                stallreq_from_mem,
    input  logic                ex_mc_start,
    input  logic [MC_CNT_W-1:0] ex_mc_cycles,
    input  logic                excp_valid,
    input  logic [PC_W-1:0]     excp_vector,
    output logic [5:0]          stall,
    output logic                flush,
    output logic [PC_W-1:0]     new_pc,
    output logic                ex_mc_busy,
    output logic                ex_mc_done,
    output logic [PERF_W-1:0]   stall_cycles,
    output logic [1:0]          mc_state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    mc_state_t             state, state_nxt;
    logic [MC_CNT_W-1:0]   cnt, cnt_nxt;
    logic                  ex_stall;

    assign mc_state_dbg = state;
    assign ex_mc_busy   = (state != IDLE);

    // A zero-length op is a no-op: it never stalls and never reaches DONE.
    assign ex_stall = ((state == IDLE) && ex_mc_start && (ex_mc_cycles != '0))
                      || (state == BUSY);

    // Stall arbitration, highest priority first; reset forces everything quiet.
    always_comb begin
        stall  = 6'b000000;
        flush  = 1'b0;
        new_pc = '0;
        if (!rst) begin
            if (excp_valid) begin
                flush  = 1'b1;
                new_pc = excp_vector;
            end else if (stallreq_from_mem) begin
                stall = 6'b011111;
            end else if (stallreq_from_ex || ex_stall) begin
                stall = 6'b001111;
            end else if (stallreq_from_id) begin
                stall = 6'b000111;
            end
        end
    end

    // Sequencer: BUSY counts down the remaining N-2 cycles regardless of downstream stalls.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (excp_valid) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ex_mc_start && (ex_mc_cycles > MC_CNT_W'(1))) begin
                        state_nxt = BUSY;
                        cnt_nxt   = ex_mc_cycles - MC_CNT_W'(2);
                    end else if (ex_mc_start && (ex_mc_cycles == MC_CNT_W'(1))) begin
                        state_nxt = DONE;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt - MC_CNT_W'(1);
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ex_mc_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ex_mc_done <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall[0] && (stall_cycles != {PERF_W{1'b1}})) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenario tasks plus a randomized run against
// a cycle-count reference model; a PERF_W=4 instance covers counter saturation.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_from_id, stallreq_from_ex, stallreq_from_mem;
    logic        ex_mc_start;
    logic [5:0]  ex_mc_cycles;
    logic        excp_valid;
    logic [31:0] excp_vector;

    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        ex_mc_busy, ex_mc_done;
    logic [31:0] stall_cycles;
    logic [1:0]  mc_state_dbg;

    logic [5:0]  s_stall;
    logic        s_flush;
    logic [31:0] s_new_pc;
    logic        s_busy, s_done;
    logic [3:0]  s_stall_cycles;
    logic [1:0]  s_state_dbg;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .stallreq_from_id(stallreq_from_id), .stallreq_from_ex(stallreq_from_ex),
        .stallreq_from_mem(stallreq_from_mem), .ex_mc_start(ex_mc_start),
        .ex_mc_cycles(ex_mc_cycles), .excp_valid(excp_valid), .excp_vector(excp_vector),
        .stall(stall), .flush(flush), .new_pc(new_pc), .ex_mc_busy(ex_mc_busy),
        .ex_mc_done(ex_mc_done), .stall_cycles(stall_cycles), .mc_state_dbg(mc_state_dbg)
    );

    pipe_ctrl #(.PERF_W(4)) dut_small (
        .clk(clk), .rst(rst),
        .stallreq_from_id(stallreq_from_id), .stallreq_from_ex(stallreq_from_ex),
        .stallreq_from_mem(stallreq_from_mem), .ex_mc_start(ex_mc_start),
        .ex_mc_cycles(ex_mc_cycles), .excp_valid(excp_valid), .excp_vector(excp_vector),
        .stall(s_stall), .flush(s_flush), .new_pc(s_new_pc), .ex_mc_busy(s_busy),
        .ex_mc_done(s_done), .stall_cycles(s_stall_cycles), .mc_state_dbg(s_state_dbg)
    );

    // Applies one cycle of inputs at the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic r, input logic id, input logic ex, input logic mem,
                         input logic start, input logic [5:0] n,
                         input logic excp, input logic [31:0] vec);
        @(negedge clk);
        rst = r; stallreq_from_id = id; stallreq_from_ex = ex; stallreq_from_mem = mem;
        ex_mc_start = start; ex_mc_cycles = n; excp_valid = excp; excp_vector = vec;
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 1, 1, 6'd3, 1, 32'hDEADBEEF);
        vectors++;
        if (stall !== 6'b000000 || flush !== 1'b0 || new_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_forced: stall=%b flush=%b new_pc=%h, want 000000/0/0", stall, flush, new_pc);
        end
        drive(1, 0, 0, 0, 0, 6'd0, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 6'd0, 0, 32'h0);
        vectors++;
        if (stall !== 6'b000000 || flush !== 1'b0 || ex_mc_busy !== 1'b0 ||
            ex_mc_done !== 1'b0 || stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_idle: stall=%b flush=%b busy=%b done=%b cyc=%0d, want 0/0/0/0/0",
                     stall, flush, ex_mc_busy, ex_mc_done, stall_cycles);
        end
    endtask

    task automatic test_priority();
        drive(0, 1, 0, 1, 0, 6'd0, 0, 32'h0);
        vectors++;
        if (stall !== 6'b011111) begin
            errors++; $display("FAIL prio_id_mem: stall=%b want 011111", stall);
        end
        drive(0, 1, 0, 0, 0, 6'd0, 0, 32'h0);
        vectors++;
        if (stall !== 6'b000111) begin
            errors++; $display("FAIL prio_id_only: stall=%b want 000111", stall);
        end
        drive(0, 1, 1, 0, 0, 6'd0, 0, 32'h0);
        vectors++;
        if (stall !== 6'b001111) begin
            errors++; $display("FAIL prio_ex_id: stall=%b want 001111", stall);
        end
        drive(0, 1, 1, 1, 0, 6'd0, 1, 32'h12345678);
        vectors++;
        if (stall !== 6'b000000 || flush !== 1'b1 || new_pc !== 32'h12345678) begin
            errors++;
            $display("FAIL prio_excp: stall=%b flush=%b new_pc=%h want 000000/1/12345678", stall, flush, new_pc);
        end
        drive(0, 0, 0, 0, 0, 6'd0, 0, 32'h0);
        vectors++;
        if (flush !== 1'b0 || new_pc !== 32'h0) begin
            errors++; $display("FAIL prio_no_flush: flush=%b new_pc=%h want 0/0", flush, new_pc);
        end
    endtask

    task automatic test_mc_n5();
        logic [31:0] c0;
        drive(0, 0, 0, 0, 1, 6'd5, 0, 32'h0);
        c0 = stall_cycles;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) drive(0, 0, 0, 0, 0, 6'd0, 0, 32'h0);
            vectors++;
            if (stall !== 6'b001111 || ex_mc_done !== 1'b0) begin
                errors++; $display("FAIL mc5_stall[%0d]: stall=%b done=%b want 001111/0", k, stall, ex_mc_done);
            end
        end
        drive(0, 0, 0, 0, 0, 6'd0, 0, 32'h0);
        vectors++;
        if (stall !== 6'b000000 || ex_mc_done !== 1'b1 || stall_cycles !== c0 + 32'd5) begin
            errors++;
            $display("FAIL mc5_done: stall=%b done=%b cyc=%0d want 000000/1/%0d", stall, ex_mc_done, stall_cycles, c0 + 5);
        end
        drive(0, 0, 0, 0, 0, 6'd0, 0, 32'h0);
        vectors++;
        if (ex_mc_done !== 1'b0 || ex_mc_busy !== 1'b0) begin
            errors++; $display("FAIL mc5_after: done=%b busy=%b want 0/0", ex_mc_done, ex_mc_busy);
        end
    endtask

    task automatic test_mc_short();
        drive(0, 0, 0, 0, 1, 6'd1, 0, 32'h0);
        vectors++;
        if (stall !== 6'b001111) begin
            errors++; $display("FAIL mc1_stall: stall=%b want 001111", stall);
        end
        drive(0, 0, 0, 0, 0, 6'd0, 0, 32'h0);
        vectors++;
        if (stall !== 6'b000000 || ex_mc_done !== 1'b1) begin
            errors++; $display("FAIL mc1_done: stall=%b done=%b want 000000/1", stall, ex_mc_done);
        end
        drive(0, 0, 0, 0, 1, 6'd0, 0, 32'h0);
        vectors++;
        if (stall !== 6'b000000) begin
            errors++; $display("FAIL mc0_stall: stall=%b want 000000", stall);
        end
        drive(0, 0, 0, 0, 0, 6'd0, 0, 32'h0);
        vectors++;
        if (ex_mc_done !== 1'b0 || ex_mc_busy !== 1'b0) begin
            errors++; $display("FAIL mc0_nodone: done=%b busy=%b want 0/0", ex_mc_done, ex_mc_busy);
        end
    endtask

    task automatic test_flush_mid_op();
        int pulses = 0;
        drive(0, 0, 0, 0, 1, 6'd8, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 6'd0, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 6'd0, 0, 32'h0);
        drive(0, 0, 0, 0, 1, 6'd4, 1, 32'hBFC00380);
        vectors++;
        if (stall !== 6'b000000 || flush !== 1'b1 || new_pc !== 32'hBFC00380 || ex_mc_busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_cycle: stall=%b flush=%b new_pc=%h busy=%b want 000000/1/bfc00380/1",
                     stall, flush, new_pc, ex_mc_busy);
        end
        drive(0, 0, 0, 0, 0, 6'd0, 0, 32'h0);
        vectors++;
        if (ex_mc_busy !== 1'b0 || stall !== 6'b000000) begin
            errors++; $display("FAIL flush_idle: busy=%b stall=%b want 0/000000", ex_mc_busy, stall);
        end
        for (int k = 0; k < 10; k++) begin
            if (ex_mc_done === 1'b1) pulses++;
            drive(0, 0, 0, 0, 0, 6'd0, 0, 32'h0);
        end
        vectors++;
        if (pulses != 0) begin
            errors++; $display("FAIL flush_no_done: saw %0d done pulses, want 0", pulses);
        end
    endtask

    // Reference: an op of N cycles stalls N consecutive cycles and reports done on the next one.
    task automatic test_random();
        int          busy_left = 0;
        bit          done_now  = 0;
        logic [31:0] perf      = 0;
        logic        id, ex, mem, start, excp;
        logic [5:0]  n;
        logic [31:0] vec;
        logic [5:0]  exp_stall;
        bit          idle, mc_stall;
        drive(1, 0, 0, 0, 0, 6'd0, 0, 32'h0);
        for (int c = 0; c < 400; c++) begin
            id    = ($urandom_range(0, 3) == 0);
            ex    = ($urandom_range(0, 7) == 0);
            mem   = ($urandom_range(0, 5) == 0);
            start = ($urandom_range(0, 3) == 0);
            n     = 6'($urandom_range(0, 9));
            excp  = ($urandom_range(0, 24) == 0);
            vec   = $urandom;
            drive(0, id, ex, mem, start, n, excp, vec);

            idle     = (busy_left == 0) && !done_now;
            mc_stall = (busy_left > 0) || (idle && start && n != 0);
            if (excp)              exp_stall = 6'b000000;
            else if (mem)          exp_stall = 6'b011111;
            else if (ex || mc_stall) exp_stall = 6'b001111;
            else if (id)           exp_stall = 6'b000111;
            else                   exp_stall = 6'b000000;

            vectors++;
            if (stall !== exp_stall || flush !== excp || new_pc !== (excp ? vec : 32'h0) ||
                ex_mc_done !== done_now || ex_mc_busy !== ((busy_left > 0) || done_now) ||
                stall_cycles !== perf) begin
                errors++;
                $display("FAIL rand[%0d]: stall=%b/%b flush=%b/%b pc=%h done=%b/%b busy=%b cyc=%0d/%0d",
                         c, stall, exp_stall, flush, excp, new_pc, ex_mc_done, done_now,
                         ex_mc_busy, stall_cycles, perf);
            end

            if (exp_stall[0]) perf = perf + 1;
            if (excp) begin
                busy_left = 0; done_now = 0;
            end else if (busy_left > 0) begin
                busy_left--; done_now = (busy_left == 0);
            end else if (idle && start && n != 0) begin
                busy_left = int'(n) - 1; done_now = (n == 6'd1);
            end else begin
                done_now = 0;
            end
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        drive(1, 0, 0, 0, 0, 6'd0, 0, 32'h0);
        for (int i = 0; i < 22; i++) begin
            drive(0, 1, 0, 0, 0, 6'd0, 0, 32'h0);
            exp_cnt = (i > 15) ? 15 : i;
            vectors++;
            if (s_stall_cycles !== 4'(exp_cnt)) begin
                errors++; $display("FAIL sat[%0d]: stall_cycles=%0d want %0d", i, s_stall_cycles, exp_cnt);
            end
        end
    endtask

    initial begin
        rst = 1; stallreq_from_id = 0; stallreq_from_ex = 0; stallreq_from_mem = 0;
        ex_mc_start = 0; ex_mc_cycles = 0; excp_valid = 0; excp_vector = 0;
        test_reset();
        test_priority();
        test_mc_n5();
        test_mc_short();
        test_flush_mid_op();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
